// File: rtl/membit_scan_reader.sv
// Scan reader for two AND-matched register banks: streams per-entry upper/lower
// half match bits over valid/ready in address order and reports a hit count.
module membit_scan_reader #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_hi,
    output logic              out_lo,
    output logic              done,
    output logic [ADDR_W:0]   hit_count
);

    localparam int                HALF      = WIDTH / 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  bank_a [DEPTH];
    logic [WIDTH-1:0]  bank_b [DEPTH];
    logic [ADDR_W:0]   hit_acc;

    logic [ADDR_W-1:0] load_addr;
    logic [WIDTH-1:0]  load_match;
    logic              load_hi;
    logic              load_lo;
    logic              load_hit;

    // The entry about to be loaded: entry 0 when starting, otherwise the next one.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load_addr = '0;
        if (state == STREAM) begin
            load_addr = out_addr + ADDR_W'(1);
        end
        load_match = bank_a[load_addr] & bank_b[load_addr];
        load_hi    = |load_match[WIDTH-1:HALF];
        load_lo    = |load_match[HALF-1:0];
        load_hit   = load_hi | load_lo;
    end

    // NOTE: the banks are small register files, so they are cleared on reset
    // like any other state rather than left uninitialised as a RAM would be.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_a[i] <= '0;
                bank_b[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_sel) begin
                bank_b[wr_addr] <= wr_data;
            end else begin
                bank_a[wr_addr] <= wr_data;
            end
        end
    end

    // NOTE: non-blocking assignments here mean the load above sees the banks as
    // they were before this edge, so a same-edge write to the loaded entry is missed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_hi    <= 1'b0;
            out_lo    <= 1'b0;
            done      <= 1'b0;
            hit_count <= '0;
            hit_acc   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= STREAM;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_addr  <= '0;
                        out_hi    <= load_hi;
                        out_lo    <= load_lo;
                        hit_acc   <= (ADDR_W + 1)'(load_hit);
                    end
                end
                STREAM: begin
                    // out_valid is always high here, so ready alone completes a beat.
                    if (out_ready) begin
                        if (out_addr == LAST_ADDR) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            hit_count <= hit_acc;
                        end else begin
                            out_addr <= load_addr;
                            out_hi   <= load_hi;
                            out_lo   <= load_lo;
                            hit_acc  <= hit_acc + (ADDR_W + 1)'(load_hit);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_membit_scan_reader.sv
// Self-checking bench for membit_scan_reader: directed scenarios plus random
// traffic, compared against a transaction-level model of the scan.
module tb_membit_scan_reader;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int HALF   = WIDTH / 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              start;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic              out_hi;
    logic              out_lo;
    logic              done;
    logic [ADDR_W:0]   hit_count;

    membit_scan_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_hi(out_hi), .out_lo(out_lo),
        .done(done), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    // Reference model: bank contents plus the scan seen as a sequence of results.
    int m_a [DEPTH];
    int m_b [DEPTH];
    bit m_busy, m_valid, m_hi, m_lo, m_done;
    int m_addr, m_acc, m_hits;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void entry_result(input int i, output bit hi, output bit lo);
        int m;
        m  = m_a[i] & m_b[i];
        hi = (m >> HALF) != 0;
        lo = (m % (1 << HALF)) != 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_a[i] = 0;
            m_b[i] = 0;
        end
        m_busy = 0; m_valid = 0; m_hi = 0; m_lo = 0; m_done = 0;
        m_addr = 0; m_acc = 0; m_hits = 0;
    endtask

    task automatic compare_all();
        check("busy", busy, m_busy);
        check("out_valid", out_valid, m_valid);
        check("out_addr", out_addr, m_addr);
        check("out_hi", out_hi, m_hi);
        check("out_lo", out_lo, m_lo);
        check("done", done, m_done);
        check("hit_count", hit_count, m_hits);
    endtask

    // One clock: drive inputs, advance the model using pre-edge bank contents,
    // then apply any write to the model banks, clock the DUT and compare.
    task automatic tick(input bit we, input bit ws, input int wa, input int wd,
                        input bit st, input bit rd);
        bit hi, lo;
        wr_en = we; wr_sel = ws; wr_addr = wa[ADDR_W-1:0]; wr_data = wd[WIDTH-1:0];
        start = st; out_ready = rd;
        m_done = 0;
        if (!m_busy) begin
            if (st) begin
                entry_result(0, hi, lo);
                m_busy = 1; m_valid = 1; m_addr = 0; m_hi = hi; m_lo = lo;
                m_acc = int'(hi | lo);
            end
        end else if (rd) begin
            if (m_addr == DEPTH - 1) begin
                m_busy = 0; m_valid = 0; m_done = 1; m_hits = m_acc;
            end else begin
                m_addr = m_addr + 1;
                entry_result(m_addr, hi, lo);
                m_hi = hi; m_lo = lo;
                m_acc = m_acc + int'(hi | lo);
            end
        end
        if (we) begin
            if (ws) m_b[wa] = wd;
            else m_a[wa] = wd;
        end
        @(posedge clk);
        #1;
        if (done) done_cnt++;
        compare_all();
        wr_en = 0;
        start = 0;
    endtask

    task automatic write(input bit ws, input int wa, input int wd);
        tick(1'b1, ws, wa, wd, 1'b0, 1'b1);
    endtask

    task automatic idle(input bit st, input bit rd);
        tick(1'b0, 1'b0, 0, 0, st, rd);
    endtask

    initial begin
        reset = 1'b1; wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0;
        start = 0; out_ready = 0;
        model_reset();
        #12;
        compare_all();
        reset = 1'b0;

        // Scan of empty banks: four all-zero results then done with no hits.
        idle(1, 1);
        repeat (4) idle(0, 1);
        check("empty_hits", hit_count, 0);

        // Reference data set.
        write(0, 0, 4'b1000); write(1, 0, 4'b1010);
        write(0, 1, 4'b0011); write(1, 1, 4'b0001);
        write(0, 2, 4'b1111); write(1, 2, 4'b0000);
        write(0, 3, 4'b0100); write(1, 3, 4'b0110);

        // Full-rate scan.
        idle(1, 1);
        check("e0_hi", out_hi, 1);
        repeat (4) idle(0, 1);
        check("full_done", done, 1);
        check("full_hits", hit_count, 3);

        // Back-pressure while entry 1 is presented.
        idle(1, 0);
        idle(0, 1);
        repeat (3) idle(0, 0);
        check("stall_addr", out_addr, 1);
        check("stall_lo", out_lo, 1);
        repeat (3) idle(0, 1);
        check("stall_hits", hit_count, 3);

        // Mid-scan writes: same-edge write to loaded entry missed, later one seen.
        idle(1, 0);
        tick(1, 1, 1, 4'b1111, 0, 1);
        check("collide_lo", out_lo, 1);
        tick(1, 1, 3, 4'b0000, 0, 1);
        idle(0, 1);
        check("e3_hi", out_hi, 0);
        idle(0, 1);
        check("midwr_hits", hit_count, 2);

        // Start held while busy is ignored; start in the done cycle is accepted.
        done_cnt = 0;
        idle(1, 1);
        repeat (4) idle(1, 1);
        check("one_done", done_cnt, 1);
        idle(1, 1);
        check("restart_busy", busy, 1);
        repeat (4) idle(0, 1);

        // Asynchronous reset mid-scan, then a rescan of cleared banks.
        idle(1, 1);
        idle(0, 1);
        idle(0, 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_busy", busy, 0);
        check("async_valid", out_valid, 0);
        check("async_done", done, 0);
        compare_all();
        #2 reset = 1'b0;
        idle(1, 1);
        repeat (4) idle(0, 1);
        check("rescan_hits", hit_count, 0);

        // Random traffic: writes, back-pressure and start requests in any state.
        for (int n = 0; n < 300; n++) begin
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
